memlibc_mbist_ctrl_scheduler: RTL and testbench
===============================================

MEMLIBC_MBIST_CTRL_SCHEDULER -- requirements
Module: memlibc_mbist_ctrl_scheduler

Interface
REQ-001 SHALL have parameter NUM_CTRL, default 4: number of memory BIST controllers sequenced, range 1..16.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: cycles between reset release and start, range 2..255; covers the controller-side 2-flop reset synchronizer.
REQ-003 SHALL have parameter TIMEOUT_W, default 16: watchdog counter width.
REQ-004 clk  input  1  sole clock; all logic on posedge clk.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; a 0->1 edge sampled while idle launches a run.
REQ-007 ctrl_en  input  NUM_CTRL  per-controller enable mask; sampled at launch.
REQ-008 ctrl_done  input  NUM_CTRL  per-controller completion level.
REQ-009 ctrl_fail  input  NUM_CTRL  per-controller fail level; valid when ctrl_done is high.
REQ-010 ctrl_rn  output  NUM_CTRL  per-controller active-low reset, registered.
REQ-011 ctrl_start  output  NUM_CTRL  per-controller one-cycle start pulse, registered.
REQ-012 busy, done, pass  output  1 each  run status.
REQ-013 fail_vec, timeout_vec  output  NUM_CTRL each  sticky per-controller result.

Function
REQ-014 SHALL implement FSM states IDLE, RELEASE, LAUNCH, WAIT, RETIRE, FINISH.
REQ-015 IDLE: on a start rising edge, latch ctrl_en, clear fail_vec/timeout_vec/done/pass, set index to the lowest enabled controller, go to RELEASE; with an all-zero mask, go directly to FINISH.
REQ-016 RELEASE: drive ctrl_rn[index]=1, count SETTLE_CYCLES cycles, then go to LAUNCH.
REQ-017 LAUNCH: drive ctrl_start[index]=1 for exactly one cycle, then go to WAIT.
REQ-018 WAIT: when ctrl_done[index]=1, capture ctrl_fail[index] into fail_vec[index] and go to RETIRE; ignore ctrl_done in the LAUNCH cycle.
REQ-019 RETIRE: drive ctrl_rn[index]=0; advance to the next higher enabled index and go to RELEASE, or go to FINISH if none remains.
REQ-020 FINISH: set done=1 and pass=~|(fail_vec|timeout_vec) for a whole run; hold both until the next launch; go to IDLE.
REQ-021 SHALL hold busy=1 in every state except IDLE.
REQ-022 SHALL release at most one controller from reset at any time; all other ctrl_rn bits SHALL be 0.
REQ-023 SHALL never pulse ctrl_start on a controller whose ctrl_rn is 0.
REQ-024 SHALL ignore start while busy; a held-high start SHALL NOT relaunch a run without first going low.
REQ-025 SHALL ignore ctrl_en changes during a run.
REQ-026 SHALL treat done/fail bits of non-indexed controllers as don't-care.

Reset
REQ-027 When rst=1 at a clk edge: state=IDLE; ctrl_rn=0; ctrl_start=0; busy=0; done=0; pass=0; fail_vec=0; timeout_vec=0; all counters=0; start edge detector=0.
REQ-028 Reset mid-run SHALL abort immediately, with no further ctrl_start pulses.

Configuration
REQ-029 Macro MEMLIBC_MBIST_SCHED_TIMEOUT_EN defined: in WAIT, a TIMEOUT_W-bit counter SHALL increment each cycle. At all-ones it SHALL set timeout_vec[index] and go to RETIRE. A done arriving in the same cycle SHALL win, and timeout_vec SHALL remain 0.
REQ-030 Macro not defined: WAIT SHALL wait indefinitely; timeout_vec SHALL be constant 0, with no counter logic.

Verification
REQ-031 NUM_CTRL=4, ctrl_en=4'b1111, each done 10 cycles after its start, no fails -> starts in order 0,1,2,3; each start SETTLE_CYCLES after its ctrl_rn rise; done=1, pass=1, fail_vec=0.
REQ-032 ctrl_en=4'b1010, ctrl_fail[3]=1 -> only controllers 1 and 3 released/started; fail_vec=4'b1000; pass=0.
REQ-033 ctrl_en=0, start edge -> done=1, pass=1 within 3 cycles; no ctrl_rn or ctrl_start activity.
REQ-034 rst asserted 2 cycles after ctrl_start[0] -> next cycle ctrl_rn=0, busy=0, and ctrl_start stays 0 thereafter.
REQ-035 With the macro defined and TIMEOUT_W=4, controller 2 never asserts done -> timeout_vec=4'b0100 after 15 WAIT cycles; controller 3 still runs; pass=0.
REQ-036 start held high across run end -> exactly one run; a new run only after start goes 0 then 1.

Source files
------------

// File: rtl/memlibc_mbist_ctrl_scheduler.sv
// Sequences memory BIST controllers one at a time: reset release, settle, start, wait, retire.
// Ports: clk/rst (sync, active-high), start, ctrl_en/done/fail in; ctrl_rn/start, busy/done/pass, fail_vec/timeout_vec out.
// Optional watchdog in WAIT enabled by defining MEMLIBC_MBIST_SCHED_TIMEOUT_EN.
module memlibc_mbist_ctrl_scheduler #(
    parameter int unsigned NUM_CTRL      = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_CTRL-1:0] ctrl_en,
    input  logic [NUM_CTRL-1:0] ctrl_done,
    input  logic [NUM_CTRL-1:0] ctrl_fail,
    output logic [NUM_CTRL-1:0] ctrl_rn,
    output logic [NUM_CTRL-1:0] ctrl_start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [NUM_CTRL-1:0] fail_vec,
    output logic [NUM_CTRL-1:0] timeout_vec
);

    localparam int unsigned IDX_W = (NUM_CTRL > 1) ? $clog2(NUM_CTRL) : 1;
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        RELEASE,
        LAUNCH,
        WAIT,
        RETIRE,
        FINISH
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [NUM_CTRL-1:0] en_q, en_d;
    logic [7:0]          settle_cnt, settle_d;
    logic                start_q;
    logic                start_rise;
    logic [NUM_CTRL-1:0] fail_d;
    logic                done_d, pass_d;
    logic [NUM_CTRL-1:0] rn_d, st_d;
    logic [IDX_W-1:0]    first_idx, next_idx;
    logic                first_any, next_any;

    assign start_rise = start & ~start_q;
    assign busy       = (state != IDLE);

`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt, wd_d;
    logic [NUM_CTRL-1:0]  tmo_q, tmo_d;

    assign timeout_vec = tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            tmo_q  <= '0;
        end else begin
            wd_cnt <= wd_d;
            tmo_q  <= tmo_d;
        end
    end
`else
    // No watchdog: WAIT blocks until the indexed controller reports done.
    logic unused_tw;
    assign unused_tw   = (TIMEOUT_W > 0);
    assign timeout_vec = '0;
`endif

    // Lowest enabled controller in the live mask (used at launch).
    always_comb begin
        first_idx = '0;
        first_any = 1'b0;
        for (int i = NUM_CTRL - 1; i >= 0; i--) begin
            if (ctrl_en[i]) begin
                first_idx = IDX_W'(i);
                first_any = 1'b1;
            end
        end
    end

    // Next enabled controller above the current one in the latched mask.
    always_comb begin
        next_idx = '0;
        next_any = 1'b0;
        for (int i = NUM_CTRL - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(idx))) begin
                next_idx = IDX_W'(i);
                next_any = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        en_d     = en_q;
        settle_d = '0;
        fail_d   = fail_vec;
        done_d   = done;
        pass_d   = pass;
`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
        wd_d     = '0;
        tmo_d    = tmo_q;
`endif
        unique case (state)
            IDLE: begin
                if (start_rise) begin
                    en_d    = ctrl_en;
                    fail_d  = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    idx_d   = first_idx;
                    state_d = first_any ? RELEASE : FINISH;
`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            RELEASE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = LAUNCH;
                end else begin
                    settle_d = settle_cnt + 8'd1;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (ctrl_done[idx]) begin
                    fail_d[idx] = ctrl_fail[idx];
                    state_d     = RETIRE;
                end
`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
                else if (&wd_cnt) begin
                    tmo_d[idx] = 1'b1;
                    state_d    = RETIRE;
                end else begin
                    wd_d = wd_cnt + TIMEOUT_W'(1);
                end
`endif
            end
            RETIRE: begin
                if (next_any) begin
                    idx_d   = next_idx;
                    state_d = RELEASE;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                pass_d  = ~|(fail_vec | timeout_vec);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller outputs are registered from the next state so reset
    // release and start pulse line up with the state they belong to.
    always_comb begin
        rn_d = '0;
        st_d = '0;
        if (state_d == RELEASE || state_d == LAUNCH || state_d == WAIT) begin
            rn_d[idx_d] = 1'b1;
        end
        if (state_d == LAUNCH) begin
            st_d[idx_d] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            en_q       <= '0;
            settle_cnt <= '0;
            start_q    <= 1'b0;
            fail_vec   <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            ctrl_rn    <= '0;
            ctrl_start <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            en_q       <= en_d;
            settle_cnt <= settle_d;
            start_q    <= start;
            fail_vec   <= fail_d;
            done       <= done_d;
            pass       <= pass_d;
            ctrl_rn    <= rn_d;
            ctrl_start <= st_d;
        end
    end

endmodule

// File: tb/tb_memlibc_mbist_ctrl_scheduler.sv
// Self-checking bench for memlibc_mbist_ctrl_scheduler with behavioural BIST controllers.
// Expected results come from the enable/fail/hang masks and the launch order rule.
module tb_memlibc_mbist_ctrl_scheduler;

    localparam int NC     = 4;
    localparam int SETTLE = 4;
    localparam int TW     = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [NC-1:0] ctrl_en, ctrl_done, ctrl_fail;
    logic [NC-1:0] ctrl_rn, ctrl_start, fail_vec, timeout_vec;
    logic          busy, done, pass;

    memlibc_mbist_ctrl_scheduler #(
        .NUM_CTRL(NC),
        .SETTLE_CYCLES(SETTLE),
        .TIMEOUT_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ctrl_en(ctrl_en),
        .ctrl_done(ctrl_done),
        .ctrl_fail(ctrl_fail),
        .ctrl_rn(ctrl_rn),
        .ctrl_start(ctrl_start),
        .busy(busy),
        .done(done),
        .pass(pass),
        .fail_vec(fail_vec),
        .timeout_vec(timeout_vec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural controllers
    logic [NC-1:0] fail_cfg = '0;
    logic [NC-1:0] hang_cfg = '0;
    int            dly_cfg[NC];
    int            rcnt[NC];
    bit            rdone[NC];

    initial begin
        ctrl_done = '0;
        ctrl_fail = '0;
        for (int i = 0; i < NC; i++) begin
            rcnt[i]    = -1;
            rdone[i]   = 1'b0;
            dly_cfg[i] = 10;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NC; i++) begin
                if (!ctrl_rn[i]) begin
                    // Held in reset: outputs are garbage the scheduler must ignore.
                    rcnt[i]      = -1;
                    rdone[i]     = 1'b0;
                    ctrl_done[i] = 1'($urandom_range(0, 1));
                    ctrl_fail[i] = 1'($urandom_range(0, 1));
                end else if (ctrl_start[i]) begin
                    if (!hang_cfg[i]) rcnt[i] = dly_cfg[i];
                    ctrl_done[i] = 1'b0;
                    ctrl_fail[i] = 1'($urandom_range(0, 1));
                end else if (rdone[i]) begin
                    ctrl_done[i] = 1'b1;
                    ctrl_fail[i] = fail_cfg[i];
                end else if (rcnt[i] > 0) begin
                    rcnt[i]--;
                    if (rcnt[i] == 0) begin
                        rdone[i]     = 1'b1;
                        ctrl_done[i] = 1'b1;
                        ctrl_fail[i] = fail_cfg[i];
                    end else begin
                        ctrl_done[i] = 1'b0;
                        ctrl_fail[i] = 1'($urandom_range(0, 1));
                    end
                end else begin
                    ctrl_done[i] = 1'b0;
                    ctrl_fail[i] = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    // Protocol monitor
    int            start_log[$];
    int            rn_rises = 0;
    int            cyc = 0;
    int            rise_cyc[NC];
    logic [NC-1:0] prev_rn = '0;
    logic [NC-1:0] prev_st = '0;

    initial begin
        for (int i = 0; i < NC; i++) rise_cyc[i] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            check("one_rn", 32'($countones(ctrl_rn) <= 1), 1);
            check("start_needs_rn", 32'(ctrl_start & ~ctrl_rn), 0);
            check("start_one_cycle", 32'(ctrl_start & prev_st), 0);
            for (int i = 0; i < NC; i++) begin
                if (ctrl_rn[i] && !prev_rn[i]) begin
                    rise_cyc[i] = cyc;
                    rn_rises++;
                end
                if (ctrl_start[i] && !prev_st[i]) begin
                    check("settle_gap", 32'(cyc - rise_cyc[i]), SETTLE);
                    start_log.push_back(i);
                end
            end
            prev_rn = ctrl_rn;
            prev_st = ctrl_start;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_case(input string tag, input logic [NC-1:0] en,
                            input logic [NC-1:0] fl, input logic [NC-1:0] hg,
                            input int dmin, input int dmax, input bit hold);
        int            exp_q[$];
        logic [NC-1:0] exp_fail, exp_tmo;
        int            waited;
        bit            got;
        fail_cfg = fl;
        hang_cfg = hg;
        for (int i = 0; i < NC; i++) begin
            dly_cfg[i] = $urandom_range(dmin, dmax);
            if (en[i]) exp_q.push_back(i);
        end
        exp_fail = en & fl & ~hg;
`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
        exp_tmo  = en & hg;
`else
        exp_tmo  = '0;
`endif
        start_log.delete();
        rn_rises = 0;
        ctrl_en  = en;
        start    = 1'b1;
        @(negedge clk);
        check({tag, "_busy_launch"}, 32'(busy), 1);
        check({tag, "_done_cleared"}, 32'(done), 0);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 3000) begin
            if (!hold) start = 1'($urandom_range(0, 1));
            ctrl_en = NC'($urandom);
            @(negedge clk);
            waited++;
            if (done) got = 1'b1;
        end
        if (!hold) start = 1'b0;
        #1;
        check({tag, "_done_seen"}, 32'(got), 1);
        if (en == '0) check({tag, "_fast_finish"}, 32'(waited <= 3), 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
        check({tag, "_fail_vec"}, 32'(fail_vec), 32'(exp_fail));
        check({tag, "_timeout_vec"}, 32'(timeout_vec), 32'(exp_tmo));
        check({tag, "_pass"}, 32'(pass), 32'((exp_fail | exp_tmo) == '0));
        check({tag, "_releases"}, 32'(rn_rises), 32'(exp_q.size()));
        check({tag, "_starts"}, 32'(start_log.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < start_log.size(); k++) begin
            check({tag, "_order"}, 32'(start_log[k]), 32'(exp_q[k]));
        end
    endtask

    initial begin
        int  n_before;
        bit  found;
        rst     = 1'b1;
        start   = 1'b0;
        ctrl_en = '0;
        tick(3);
        check("rst_rn", 32'(ctrl_rn), 0);
        check("rst_start", 32'(ctrl_start), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_fail_vec", 32'(fail_vec), 0);
        check("rst_timeout_vec", 32'(timeout_vec), 0);
        rst = 1'b0;
        tick(2);

        run_case("all4", 4'b1111, 4'b0000, 4'b0000, 10, 10, 1'b0);
        tick(3);
        run_case("odd", 4'b1010, 4'b1000, 4'b0000, 1, 20, 1'b0);
        tick(3);
        run_case("none", 4'b0000, 4'b1111, 4'b0000, 1, 5, 1'b0);
        tick(3);

        for (int r = 0; r < 8; r++) begin
            run_case("rand", NC'($urandom), NC'($urandom), 4'b0000,
                     1, 20, 1'b0);
            tick($urandom_range(1, 4));
        end

        // start held high across the end of a run
        run_case("hold", 4'b0110, 4'b0000, 4'b0000, 1, 8, 1'b1);
        n_before = start_log.size();
        tick(40);
        check("hold_no_relaunch", 32'(start_log.size()), 32'(n_before));
        check("hold_idle", 32'(busy), 0);
        check("hold_done_kept", 32'(done), 1);
        start = 1'b0;
        tick(2);
        run_case("after_hold", 4'b0001, 4'b0001, 4'b0000, 1, 8, 1'b0);
        tick(3);

`ifdef MEMLIBC_MBIST_SCHED_TIMEOUT_EN
        run_case("hang2", 4'b1111, 4'b0000, 4'b0100, 1, 20, 1'b0);
        tick(3);
`else
        // Without a watchdog a silent controller stalls the run forever.
        fail_cfg = '0;
        hang_cfg = 4'b0100;
        ctrl_en  = 4'b0100;
        start    = 1'b1;
        tick(1);
        start = 1'b0;
        tick(300);
        check("hang_still_busy", 32'(busy), 1);
        check("hang_no_done", 32'(done), 0);
        check("hang_no_timeout", 32'(timeout_vec), 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        hang_cfg = '0;
        tick(2);
`endif

        // reset two cycles after the first start pulse
        fail_cfg = '0;
        hang_cfg = '0;
        for (int i = 0; i < NC; i++) dly_cfg[i] = 10;
        start_log.delete();
        ctrl_en = 4'b1111;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (ctrl_start[0]) found = 1'b1;
            else tick(1);
        end
        check("abort_start_seen", 32'(found), 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("abort_rn", 32'(ctrl_rn), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_start", 32'(ctrl_start), 0);
        rst = 1'b0;
        tick(60);
        #1;
        check("abort_no_more_starts", 32'(start_log.size()), 1);
        check("abort_idle", 32'(busy), 0);
        check("abort_done", 32'(done), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
